mic_period_meter: RTL and testbench

MIC_PERIOD_METER -- requirements
Module: mic_period_meter

---
 rtl/mic_period_meter_pkg.sv | 44 ++++
 rtl/mic_period_meter_averager.sv | 54 +++++
 rtl/mic_period_meter.sv | 101 ++++++++++
 tb/tb_mic_period_meter.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/mic_period_meter_pkg.sv
// note_pkg: constants and types shared between the period meter and the
// downstream note recognizer. Nominal note frequencies are in units of
// 0.01 Hz, octave 4, equal temperament referenced to A4 = 440 Hz.
package note_pkg;

    // Default width of the period counter and period output.
    localparam int w_period_default = 20;

    // One-hot note vector, bit 0 = C up to bit 11 = B.
    typedef logic [11:0] note_t;

    localparam note_t note_c  = 12'b0000_0000_0001;
    localparam note_t note_cs = 12'b0000_0000_0010;
    localparam note_t note_d  = 12'b0000_0000_0100;
    localparam note_t note_ds = 12'b0000_0000_1000;
    localparam note_t note_e  = 12'b0000_0001_0000;
    localparam note_t note_f  = 12'b0000_0010_0000;
    localparam note_t note_fs = 12'b0000_0100_0000;
    localparam note_t note_g  = 12'b0000_1000_0000;
    localparam note_t note_gs = 12'b0001_0000_0000;
    localparam note_t note_a  = 12'b0010_0000_0000;
    localparam note_t note_as = 12'b0100_0000_0000;
    localparam note_t note_b  = 12'b1000_0000_0000;

    // Nominal frequencies x100 (Hz * 100).
    localparam int freq_100_c  = 26163;
    localparam int freq_100_cs = 27718;
    localparam int freq_100_d  = 29366;
    localparam int freq_100_ds = 31113;
    localparam int freq_100_e  = 32963;
    localparam int freq_100_f  = 34923;
    localparam int freq_100_fs = 36999;
    localparam int freq_100_g  = 39200;
    localparam int freq_100_gs = 41530;
    localparam int freq_100_a  = 44000;
    localparam int freq_100_as = 46616;
    localparam int freq_100_b  = 49388;

    // Nominal period in clocks for a given clock (MHz) and note frequency x100.
    function automatic int nominal_period(input int clk_mhz, input int freq_100);
        return (clk_mhz * 100_000_000) / freq_100;
    endfunction

endpackage

// File: rtl/mic_period_meter_averager.sv
// period_averager: sums 2**n_avg_log2 captured periods, publishes the
// truncated mean and pulses period_valid. flush clears everything,
// including the published period.
module period_averager
    import note_pkg::*;
#(
    parameter int w_period   = w_period_default,
    parameter int n_avg_log2 = 2
) (
    input  logic                clk,
    input  logic                flush,
    input  logic                cap_vld,
    input  logic [w_period-1:0] cap_val,
    output logic [w_period-1:0] period,
    output logic                period_valid
);

    localparam int w_acc = w_period + n_avg_log2;
    localparam int w_cc  = n_avg_log2 + 1;
    localparam int n_cap = 1 << n_avg_log2;

    logic [w_acc-1:0] r_acc;
    logic [w_cc-1:0]  r_cc;
    logic [w_acc-1:0] w_sum;
    logic             w_last;

    assign w_sum  = r_acc + w_acc'(cap_val);
    assign w_last = (r_cc == w_cc'(n_cap - 1));

    // Accumulate captures; on the last of a group publish the mean (the upper
    // w_period bits of the sum are the sum shifted right by n_avg_log2).
    always_ff @(posedge clk) begin
        if (flush) begin
            r_acc        <= '0;
            r_cc         <= '0;
            period       <= '0;
            period_valid <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (cap_vld) begin
                if (w_last) begin
                    period       <= w_sum[w_acc-1:n_avg_log2];
                    period_valid <= 1'b1;
                    r_acc        <= '0;
                    r_cc         <= '0;
                end else begin
                    r_acc <= w_sum;
                    r_cc  <= r_cc + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mic_period_meter.sv
// mic_period_meter: measures the period (in clocks) of a signed microphone
// waveform from its rising crossings and reports a running average.
// Optional feature macro: MIC_PERIOD_METER_HYSTERESIS_EN -- classify with a
// +/-hyst dead band instead of the plain sign bit.
module mic_period_meter
    import note_pkg::*;
#(
    parameter int                  clk_mhz    = 50,
    parameter int                  w_sample   = 24,
    parameter int                  w_period   = w_period_default,
    parameter int                  n_avg_log2 = 2,
    parameter logic [w_sample-1:0] hyst       = 24'h000400
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [w_sample-1:0] mic,
    input  logic                clear,
    output logic [w_period-1:0] period,
    output logic                period_valid,
    output logic                signal_present,
    output logic                crossing
);

    localparam logic [1:0] ST_UNSYNC = 2'd0;
    localparam logic [1:0] ST_LOW    = 2'd1;
    localparam logic [1:0] ST_HIGH   = 2'd2;

    logic [1:0]          r_state;
    logic [w_period-1:0] r_cnt;
    logic                r_armed;
    logic                w_neg;
    logic                w_pos;
    logic                w_cross;
    logic                w_cnt_max;
    logic                w_timeout;
    logic                w_flush;
    logic                w_cap;

`ifdef MIC_PERIOD_METER_HYSTERESIS_EN
    logic signed [w_sample:0] w_mic_x;
    logic signed [w_sample:0] w_thr;

    assign w_mic_x = {mic[w_sample-1], mic};
    assign w_thr   = {1'b0, hyst};
    assign w_neg   = (w_mic_x < -w_thr);
    assign w_pos   = (w_mic_x > w_thr);
`else
    logic w_unused_mic;

    assign w_neg        = mic[w_sample-1];
    assign w_pos        = ~mic[w_sample-1];
    assign w_unused_mic = ^mic[w_sample-2:0];
`endif

    assign w_cross   = (r_state == ST_LOW) && w_pos;
    assign w_cnt_max = &r_cnt;
    // The counter only runs once armed, so saturation means a lost signal.
    assign w_timeout = r_armed && w_cnt_max;
    assign w_flush   = rst || clear || w_timeout;
    assign w_cap     = w_cross && r_armed && !w_flush;

    // Crossing FSM, period counter and presence flag; reset/clear beat
    // timeout, which beats a crossing in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || clear || w_timeout) begin
            r_state        <= ST_UNSYNC;
            r_cnt          <= '0;
            r_armed        <= 1'b0;
            crossing       <= 1'b0;
            signal_present <= 1'b0;
        end else begin
            crossing <= w_cross;
            case (r_state)
                ST_UNSYNC: if (w_neg) r_state <= ST_LOW;
                ST_LOW:    if (w_pos) r_state <= ST_HIGH;
                ST_HIGH:   if (w_neg) r_state <= ST_LOW;
                default:   r_state <= ST_UNSYNC;
            endcase
            if (w_cross) begin
                r_cnt   <= {{(w_period-1){1'b0}}, 1'b1};
                r_armed <= 1'b1;
                if (r_armed) signal_present <= 1'b1;
            end else if (r_armed && !w_cnt_max) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    period_averager #(
        .w_period   (w_period),
        .n_avg_log2 (n_avg_log2)
    ) u_avg (
        .clk          (clk),
        .flush        (w_flush),
        .cap_vld      (w_cap),
        .cap_val      (r_cnt),
        .period       (period),
        .period_valid (period_valid)
    );

endmodule

// File: tb/tb_mic_period_meter.sv
// Directed bench for mic_period_meter: two instances (4-period average and
// single-period) share one stimulus stream; a 12-bit counter keeps the
// timeout reachable in a short run.
module tb_mic_period_meter;

    localparam int WP = 12;
    localparam logic [23:0] POS  = 24'h100000;
    localparam logic [23:0] NEG  = 24'hF00000;
    localparam logic [23:0] NPOS = 24'h000200;
    localparam logic [23:0] NNEG = 24'hFFFE00;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic [23:0]   mic = NEG;
    logic [WP-1:0] period, period0;
    logic          pv, pv0, present, present0, xing, xing0;

    int checks = 0;
    int errors = 0;
    int xcnt = 0, vcnt = 0, vcnt0 = 0;
    int x0;

    always #5 clk = ~clk;

    mic_period_meter #(.w_period(WP), .n_avg_log2(2)) dut (
        .clk(clk), .rst(rst), .mic(mic), .clear(clear),
        .period(period), .period_valid(pv),
        .signal_present(present), .crossing(xing));

    mic_period_meter #(.w_period(WP), .n_avg_log2(0)) dut0 (
        .clk(clk), .rst(rst), .mic(mic), .clear(clear),
        .period(period0), .period_valid(pv0),
        .signal_present(present0), .crossing(xing0));

    always @(negedge clk) begin
        if (xing) xcnt++;
        if (pv)   vcnt++;
        if (pv0)  vcnt0++;
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic hi(input int n); mic = POS; step(n); endtask
    task automatic lo(input int n); mic = NEG; step(n); endtask
    task automatic blk(input int h, input int l); hi(h); lo(l); endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        step(3);
        chk("rst_period", int'(period), 0);
        chk("rst_valid", int'(pv), 0);
        chk("rst_present", int'(present), 0);
        chk("rst_crossing", int'(xing), 0);
        rst = 1'b0;
        lo(20);

        // Lock on a 1000-clk square wave.
        blk(500, 500);
        chk("arm_xcnt", xcnt, 1);
        chk("arm_present", int'(present), 0);
        chk("arm_vcnt", vcnt, 0);
        blk(500, 500);
        chk("cap1_present", int'(present), 1);
        chk("n0_vcnt", vcnt0, 1);
        chk("n0_period", int'(period0), 1000);
        repeat (3) blk(500, 500);
        chk("grp1_vcnt", vcnt, 1);
        chk("grp1_period", int'(period), 1000);
        repeat (4) blk(500, 500);
        chk("grp2_vcnt", vcnt, 2);
        chk("grp2_period", int'(period), 1000);

        // Alternating 998/1002; first group is 1000+998+1002+998 -> 999.
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) blk(499, 499); else blk(501, 501);
            if (i == 3) begin
                chk("alt_grp3_vcnt", vcnt, 3);
                chk("alt_grp3_period", int'(period), 999);
            end
        end
        chk("alt_grp4_vcnt", vcnt, 4);
        chk("alt_grp4_period", int'(period), 1000);
        chk("alt_n0_998", int'(period0), 998);
        blk(500, 500);
        chk("alt_n0_1002", int'(period0), 1002);
        chk("alt_n0_vcnt", vcnt0, 17);

        // Loss of signal: hold positive until the counter saturates.
        hi(2500);
        chk("pre_to_present", int'(present), 1);
        hi(1800);
        chk("to_present", int'(present), 0);
        chk("to_period", int'(period), 0);
        chk("to_period0", int'(period0), 0);
        chk("to_vcnt", vcnt, 4);
        lo(500);
        repeat (4) blk(500, 500);
        chk("relock4_vcnt", vcnt, 4);
        chk("relock4_present", int'(present), 1);
        blk(500, 500);
        chk("relock5_vcnt", vcnt, 5);
        chk("relock5_period", int'(period), 1000);

        // Clear coincident with the 3rd crossing of a group.
        repeat (2) blk(500, 500);
        x0 = xcnt;
        mic = POS; clear = 1'b1; step(1); clear = 1'b0;
        hi(499);
        chk("clr_xcnt", xcnt, x0);
        chk("clr_vcnt", vcnt, 5);
        chk("clr_present", int'(present), 0);
        chk("clr_period", int'(period), 0);
        lo(500);
        repeat (4) blk(500, 500);
        chk("clr_relock4_vcnt", vcnt, 5);
        blk(500, 500);
        chk("clr_relock5_vcnt", vcnt, 6);
        chk("clr_relock5_period", int'(period), 1000);

        // Reset mid-group discards the partial sum.
        repeat (2) blk(500, 500);
        rst = 1'b1; mic = POS; step(1);
        chk("mrst_period", int'(period), 0);
        chk("mrst_valid", int'(pv), 0);
        chk("mrst_present", int'(present), 0);
        chk("mrst_crossing", int'(xing), 0);
        rst = 1'b0;
        lo(500);
        repeat (4) blk(500, 500);
        chk("mrst_relock4_vcnt", vcnt, 6);
        blk(500, 500);
        chk("mrst_relock5_vcnt", vcnt, 7);
        chk("mrst_relock5_period", int'(period), 1000);

        // Small noise around the rising edge.
        x0 = xcnt;
        repeat (3) begin
            mic = NPOS; step(1);
            mic = NNEG; step(1);
            mic = NPOS; step(1);
            hi(497);
            lo(500);
        end
`ifdef MIC_PERIOD_METER_HYSTERESIS_EN
        chk("noise_xcnt", xcnt - x0, 3);
`else
        chk("noise_xcnt", xcnt - x0, 6);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
